// File: rtl/seg_shift_sword.sv
// Serial transmitter for a 74HC595-style display chain: shifts a parallel frame out MSB first
// on a divided serial clock, then pulses the latch strobe; start/busy/done handshake upstream.
module seg_shift_sword #(
   parameter int DATA_BITS = 64,
   parameter int HALF_DIV  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data,
   output logic                 busy,
   output logic                 done,
   output logic                 s_clk,
   output logic                 s_dat,
   output logic                 s_lat,
   output logic                 s_clrn
);

   // state  | meaning
   // IDLE   | waiting for start, chain quiet
   // SHIFT  | clocking frame bits out, one bit per 2*HALF_DIV cycles
   // LATCH  | s_lat high for HALF_DIV cycles, then done
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   localparam int PW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [PW-1:0] PH_LAST  = PW'(HALF_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   state_t               r_state, w_state_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic [PW-1:0]        r_phase, w_phase_nxt;
   logic [BW-1:0]        r_bit,   w_bit_nxt;
   logic                 r_busy,  w_busy_nxt;
   logic                 r_done,  w_done_nxt;
   logic                 r_sclk,  w_sclk_nxt;
   logic                 r_sdat,  w_sdat_nxt;
   logic                 r_slat,  w_slat_nxt;
   logic                 r_clrn;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_phase <= '0;
         r_bit   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sclk  <= 1'b0;
         r_sdat  <= 1'b0;
         r_slat  <= 1'b0;
         r_clrn  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_phase <= w_phase_nxt;
         r_bit   <= w_bit_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_sclk  <= w_sclk_nxt;
         r_sdat  <= w_sdat_nxt;
         r_slat  <= w_slat_nxt;
         r_clrn  <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_phase_nxt = r_phase;
      w_bit_nxt   = r_bit;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_sclk_nxt  = r_sclk;
      w_sdat_nxt  = r_sdat;
      w_slat_nxt  = r_slat;
      case (r_state)
         ST_IDLE: begin
            if (start && !r_busy) begin
               w_state_nxt = ST_SHIFT;
               w_shift_nxt = data;
               w_busy_nxt  = 1'b1;
               w_sdat_nxt  = data[DATA_BITS-1];
               w_sclk_nxt  = 1'b0;
               w_bit_nxt   = '0;
               w_phase_nxt = '0;
            end
         end
         ST_SHIFT: begin
            if (r_phase == PH_LAST) begin
               w_phase_nxt = '0;
               if (!r_sclk) begin
                  w_sclk_nxt = 1'b1;
               end else begin
                  // end of high phase: the chain has taken the bit, present the next one
                  w_sclk_nxt  = 1'b0;
                  w_shift_nxt = {r_shift[DATA_BITS-2:0], 1'b0};
                  if (r_bit == BIT_LAST) begin
                     w_sdat_nxt  = 1'b0;
                     w_slat_nxt  = 1'b1;
                     w_state_nxt = ST_LATCH;
                  end else begin
                     w_sdat_nxt = r_shift[DATA_BITS-2];
                     w_bit_nxt  = r_bit + 1'b1;
                  end
               end
            end else begin
               w_phase_nxt = r_phase + 1'b1;
            end
         end
         ST_LATCH: begin
            if (r_phase == PH_LAST) begin
               w_phase_nxt = '0;
               w_slat_nxt  = 1'b0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_phase_nxt = r_phase + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign s_clk  = r_sclk;
   assign s_dat  = r_sdat;
   assign s_lat  = r_slat;
   assign s_clrn = r_clrn;

endmodule

// File: tb/tb_seg_shift_sword.sv
// Bench for seg_shift_sword: an 8-bit/HALF_DIV=2 instance and a 64-bit/HALF_DIV=1 instance,
// checked against bit order and edge timing computed from frame width and divider.
module tb_seg_shift_sword;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [7:0]  data_a = '0;
   logic [63:0] data_b = '0;
   logic        busy_a, done_a, sclk_a, sdat_a, slat_a, clrn_a;
   logic        busy_b, done_b, sclk_b, sdat_b, slat_b, clrn_b;
   logic        use_b = 1'b0;
   logic        m_busy, m_done, m_sclk, m_sdat, m_slat;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   seg_shift_sword #(.DATA_BITS(8), .HALF_DIV(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .data(data_a),
      .busy(busy_a), .done(done_a), .s_clk(sclk_a), .s_dat(sdat_a), .s_lat(slat_a), .s_clrn(clrn_a));

   seg_shift_sword #(.DATA_BITS(64), .HALF_DIV(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .data(data_b),
      .busy(busy_b), .done(done_b), .s_clk(sclk_b), .s_dat(sdat_b), .s_lat(slat_b), .s_clrn(clrn_b));

   assign m_busy = use_b ? busy_b : busy_a;
   assign m_done = use_b ? done_b : done_a;
   assign m_sclk = use_b ? sclk_b : sclk_a;
   assign m_sdat = use_b ? sdat_b : sdat_a;
   assign m_slat = use_b ? slat_b : slat_a;

   task automatic drive(input bit b, input logic s, input logic [63:0] d);
      if (b) begin start_b = s; data_b = d; end
      else begin start_a = s; data_a = d[7:0]; end
   endtask

   // Sends one frame and records what the chain would see; inj_edge>0 re-asserts start mid-frame.
   task automatic run_frame(input bit b, input logic [63:0] d, input int inj_edge, input logic [63:0] inj_d,
                            output logic [63:0] got, output int nclk, output int lat_first,
                            output int lat_len, output int done_edge, output int busy_len,
                            output int tog_err);
      int   n = b ? 64 : 8;
      int   h = b ? 1 : 2;
      logic prev;
      use_b = b; got = '0; nclk = 0; lat_first = -1; lat_len = 0;
      done_edge = -1; busy_len = 0; tog_err = 0;
      @(negedge clk); drive(b, 1'b1, d);
      @(posedge clk); #1;
      drive(b, 1'b0, d);
      prev = m_sclk;
      if (m_busy) busy_len++;
      for (int k = 1; k <= 400 && done_edge < 0; k++) begin
         if (k == inj_edge) drive(b, 1'b1, inj_d);
         if (k == inj_edge + 1) drive(b, 1'b0, d);
         @(posedge clk); #1;
         if (m_sclk && !prev) begin got = {got[62:0], m_sdat}; nclk++; end
         if (k < 2*h*n) begin
            if (m_sclk !== ((k % (2*h)) >= h)) tog_err++;
         end else if (m_sclk !== 1'b0) tog_err++;
         if (m_slat) begin if (lat_first < 0) lat_first = k; lat_len++; end
         if (m_busy) busy_len++;
         if (m_done) done_edge = k;
         prev = m_sclk;
      end
   endtask

   task automatic check_frame(input bit b, input logic [63:0] d, input string nm);
      logic [63:0] got, exp_got;
      int nclk, lf, ll, de, bl, te;
      int n = b ? 64 : 8;
      int h = b ? 1 : 2;
      run_frame(b, d, 0, '0, got, nclk, lf, ll, de, bl, te);
      exp_got = b ? d : {56'd0, d[7:0]};
      checks++; if (got !== exp_got) begin failures++; $display("FAIL %s bits got=%h exp=%h", nm, got, exp_got); end
      checks++; if (nclk !== n) begin failures++; $display("FAIL %s sclk_rises got=%0d exp=%0d", nm, nclk, n); end
      checks++; if (lf !== 2*h*n) begin failures++; $display("FAIL %s lat_rise got=%0d exp=%0d", nm, lf, 2*h*n); end
      checks++; if (ll !== h) begin failures++; $display("FAIL %s lat_len got=%0d exp=%0d", nm, ll, h); end
      checks++; if (de !== 2*h*n + h) begin failures++; $display("FAIL %s done_edge got=%0d exp=%0d", nm, de, 2*h*n+h); end
      checks++; if (bl !== 2*h*n + h) begin failures++; $display("FAIL %s busy_len got=%0d exp=%0d", nm, bl, 2*h*n+h); end
      checks++; if (te !== 0) begin failures++; $display("FAIL %s sclk_shape errors=%0d exp=0", nm, te); end
      @(posedge clk); #1;
      checks++; if (m_done !== 1'b0 || m_busy !== 1'b0) begin
         failures++; $display("FAIL %s done_one_cycle done=%b busy=%b exp 0/0", nm, m_done, m_busy); end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({busy_a, done_a, sclk_a, sdat_a, slat_a, clrn_a} !== 6'b0) begin
         failures++; $display("FAIL reset_a outs=%b exp=000000", {busy_a, done_a, sclk_a, sdat_a, slat_a, clrn_a}); end
      checks++; if ({busy_b, done_b, sclk_b, sdat_b, slat_b, clrn_b} !== 6'b0) begin
         failures++; $display("FAIL reset_b outs=%b exp=000000", {busy_b, done_b, sclk_b, sdat_b, slat_b, clrn_b}); end
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (clrn_a !== 1'b0) begin failures++; $display("FAIL clrn_before_edge got=%b exp=0", clrn_a); end
      @(posedge clk); #1;
      checks++; if (clrn_a !== 1'b1 || clrn_b !== 1'b1) begin
         failures++; $display("FAIL clrn_after_edge got=%b%b exp=11", clrn_a, clrn_b); end
      checks++; if ({busy_a, done_a, sclk_a, sdat_a, slat_a} !== 5'b0) begin
         failures++; $display("FAIL idle_after_reset outs=%b exp=00000", {busy_a, done_a, sclk_a, sdat_a, slat_a}); end
   endtask

   task automatic test_single();
      check_frame(1'b0, 64'hA5, "a5");
      for (int i = 0; i < 3; i++) check_frame(1'b0, {56'd0, 8'($urandom)}, "rand8");
   endtask

   task automatic test_start_while_busy();
      logic [63:0] got;
      int nclk, lf, ll, de, bl, te, extra;
      run_frame(1'b0, 64'hA5, 10, 64'h3C, got, nclk, lf, ll, de, bl, te);
      checks++; if (got[7:0] !== 8'hA5) begin failures++; $display("FAIL busy_start bits got=%h exp=a5", got[7:0]); end
      checks++; if (nclk !== 8) begin failures++; $display("FAIL busy_start rises got=%0d exp=8", nclk); end
      checks++; if (de !== 34) begin failures++; $display("FAIL busy_start done_edge got=%0d exp=34", de); end
      extra = 0;
      repeat (4) begin @(posedge clk); #1; if (m_busy || m_done) extra++; end
      checks++; if (extra !== 0) begin failures++; $display("FAIL busy_start queued busy_cycles=%0d exp=0", extra); end
   endtask

   task automatic test_back_to_back();
      logic q[$];
      logic prev;
      int   dones[$];
      int   low_cnt = 0, rise2 = -1;
      logic [15:0] bits = '0;
      use_b = 1'b0;
      @(negedge clk); drive(1'b0, 1'b1, 64'hFF);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 64'h00);
      prev = m_sclk;
      for (int k = 1; k <= 200 && dones.size() < 2; k++) begin
         if (k == 36) drive(1'b0, 1'b0, 64'h00);
         @(posedge clk); #1;
         if (m_sclk && !prev) q.push_back(m_sdat);
         if (!m_busy) low_cnt++;
         if (m_busy && dones.size() == 1 && rise2 < 0) rise2 = k;
         if (m_done) dones.push_back(k);
         prev = m_sclk;
      end
      foreach (q[i]) if (i < 16) bits[15-i] = q[i];
      checks++; if (q.size() !== 16 || bits !== 16'hFF00) begin
         failures++; $display("FAIL b2b bits got=%h n=%0d exp=ff00 n=16", bits, q.size()); end
      checks++; if (dones.size() !== 2) begin failures++; $display("FAIL b2b done_count got=%0d exp=2", dones.size()); end
      else begin
         checks++; if (dones[0] !== 34 || dones[1] !== 69) begin
            failures++; $display("FAIL b2b done_edges got=%0d,%0d exp=34,69", dones[0], dones[1]); end
      end
      checks++; if (rise2 !== 35) begin failures++; $display("FAIL b2b second_accept got=%0d exp=35", rise2); end
      // low after the final done is also counted: one gap cycle plus the final one
      checks++; if (low_cnt !== 2) begin failures++; $display("FAIL b2b idle_cycles got=%0d exp=2", low_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_mid_reset();
      int bad = 0;
      use_b = 1'b0;
      @(negedge clk); drive(1'b0, 1'b1, {56'd0, 8'($urandom)});
      @(posedge clk); #1; drive(1'b0, 1'b0, 64'h0);
      repeat (12) @(posedge clk);
      #1;
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL midrst busy_before got=%b exp=1", busy_a); end
      rst = 1'b1; #1;
      checks++; if ({busy_a, done_a, sclk_a, sdat_a, slat_a, clrn_a} !== 6'b0) begin
         failures++; $display("FAIL midrst async outs=%b exp=000000", {busy_a, done_a, sclk_a, sdat_a, slat_a, clrn_a}); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (done_a || slat_a || busy_a) bad++; end
      checks++; if (bad !== 0) begin failures++; $display("FAIL midrst spurious cycles=%0d exp=0", bad); end
      check_frame(1'b0, 64'h81, "after_rst_81");
   endtask

   task automatic test_wide_fast();
      check_frame(1'b1, 64'h0123456789ABCDEF, "w64");
      check_frame(1'b1, {$urandom, $urandom}, "w64rand");
   endtask

   initial begin
      test_reset();
      test_single();
      test_start_while_busy();
      test_back_to_back();
      test_mid_reset();
      test_wide_fast();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout simulation did not finish exp=finish");
      $fatal(1);
   end
endmodule
